derand_parm: RTL

- Receive-side derandomizer for the OFDM PHY chain. It strips the 1+x^14+x^15 PRBS that the transmit randomizer applied.
- Processes w bits per cycle and is reloaded per burst with the same 15-bit IV that the transmitter used.
- Adds burst framing (word count, last flag) and ready/valid backpressure toward the downstream decoder.

---
 rtl/derand_parm.sv | 99 +++++++++
 1 files changed

// File: rtl/derand_parm.sv
// rtl/derand_parm.sv - receive-side 1+x^14+x^15 PRBS derandomizer, w bits/beat, burst framed.
// Optional len_err port when DERAND_ERR_EN is defined.
module derand_parm #(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [w-1:0] in_bits,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [w-1:0] out_bits,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    input  logic [14:0]  rand_iv,
    input  logic [15:0]  burst_len,
    input  logic         reload,
    output logic         busy
`ifdef DERAND_ERR_EN
    ,
    output logic         len_err
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]   state;
    logic [14:0]  vect;
    logic [15:0]  count;
    logic [14:0]  vect_step;
    logic [14:0]  next_vect;
    logic [w-1:0] mask;
    logic         accept;

    // Unrolled w-step advance; in_bits[w-1] sees the first PRBS bit.
    always_comb begin
        vect_step = vect;
        mask      = '0;
        for (int i = w - 1; i >= 0; i--) begin
            mask[i]   = vect_step[14] ^ vect_step[13];
            vect_step = {vect_step[13:0], vect_step[14] ^ vect_step[13]};
        end
        next_vect = vect_step;
    end

    assign in_ready = (state == RUN) & ~reload & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign busy     = (state == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            vect  <= '0;
            count <= '0;
        end else if (reload) begin
            // A zero-length reload cannot start a burst; in RUN it just ends the current one.
            if (burst_len != 16'd0) begin
                vect  <= rand_iv;
                count <= burst_len;
                state <= RUN;
            end else begin
                state <= IDLE;
            end
        end else if (accept) begin
            vect  <= next_vect;
            count <= count - 16'd1;
            if (count == 16'd1) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_bits  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_bits  <= in_bits ^ mask;
            out_valid <= 1'b1;
            out_last  <= (count == 16'd1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef DERAND_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_err <= 1'b0;
        end else begin
            len_err <= reload & ((state == RUN) | (burst_len == 16'd0));
        end
    end
`endif

endmodule
